crc5_arb: RTL and testbench

CRC5_ARB -- requirements
Module: crc5_arb

---
 rtl/crc5_arb_if.sv | 43 ++++
 rtl/crc5_arb.sv | 184 ++++++++++++++++++
 tb/tb_crc5_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crc5_arb_if.sv
// Requester/response bus for crc5_arb: two 64-bit requesters in, one CRC response stream out.
interface crc5_arb_if;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CRC_W  = 5;
    localparam int unsigned SEQ_W  = 4;

    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_last;
    logic              req0_ready;

    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_last;
    logic              req1_ready;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [CRC_W-1:0]  rsp_crc;
    logic              rsp_id;
    logic              rsp_last;
    logic [SEQ_W-1:0]  rsp_seq;

    // Requesters and the response consumer
    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  rsp_valid, rsp_crc, rsp_id, rsp_last, rsp_seq,
        output rsp_ready
    );

    // The arbiter itself
    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output rsp_valid, rsp_crc, rsp_id, rsp_last, rsp_seq,
        input  rsp_ready
    );
endinterface

// File: rtl/crc5_arb.sv
// Two-requester round-robin arbiter with frame lock; per-word CRC5 (x^5+x^2+1)
// tagged with requester id, last flag and per-requester word index, queued in a
// response FIFO of RSP_DEPTH entries (power of two).
module crc5_arb #(
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    crc5_arb_if.slave  bus
);
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CRC_W  = 5;
    localparam int unsigned SEQ_W  = 4;
    localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
    localparam logic [CRC_W-1:0] POLY_LO = 5'b00101;

    typedef struct packed {
        logic [CRC_W-1:0] crc;
        logic             id;
        logic             last;
        logic [SEQ_W-1:0] seq;
    } rsp_t;

    // OPEN: free arbitration; LOCKn: requester n is mid-frame and owns the grant
    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;       // requester that wins the next tie
    logic [SEQ_W-1:0] seq0_q, seq0_d;
    logic [SEQ_W-1:0] seq1_q, seq1_d;

    rsp_t             mem_q [RSP_DEPTH];
    rsp_t             mem_d [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             gnt0_c;
    logic             gnt1_c;
    logic             push_c;
    logic             pop_c;
    logic             has_space_c;
    logic             rsp_valid_c;
    rsp_t             push_entry_c;
    rsp_t             head_c;

    // CRC of one word, zero seed: shift the word MSB first through x^5+x^2+1,
    // which yields (d(x) * x^5) mod p(x)
    function automatic logic [CRC_W-1:0] crc5_word(input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ d[i];
            r  = {r[CRC_W-2:0], 1'b0};
            if (fb) begin
                r = r ^ POLY_LO;
            end
        end
        return r;
    endfunction

    assign has_space_c = (count_q < DEPTH_C);
    assign rsp_valid_c = rst_n && (count_q != '0);
    assign pop_c       = rsp_valid_c && bus.rsp_ready;
    assign push_c      = gnt0_c || gnt1_c;
    assign head_c      = mem_q[rd_ptr_q];

    // Arbitration, frame lock and seq counter next-state
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        seq0_d  = seq0_q;
        seq1_d  = seq1_q;
        gnt0_c  = 1'b0;
        gnt1_c  = 1'b0;

        case (state_q)
            ST_LOCK0: gnt0_c = bus.req0_valid;
            ST_LOCK1: gnt1_c = bus.req1_valid;
            default: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    gnt0_c = ~prio_q;
                    gnt1_c = prio_q;
                end else begin
                    gnt0_c = bus.req0_valid;
                    gnt1_c = bus.req1_valid;
                end
            end
        endcase

        // A full FIFO blocks both requesters even if the consumer pops this cycle
        if (!rst_n || !has_space_c) begin
            gnt0_c = 1'b0;
            gnt1_c = 1'b0;
        end

        if (gnt0_c) begin
            prio_d  = 1'b1;
            seq0_d  = bus.req0_last ? '0 : seq0_q + SEQ_W'(1);
            state_d = bus.req0_last ? ST_OPEN : ST_LOCK0;
        end else if (gnt1_c) begin
            prio_d  = 1'b0;
            seq1_d  = bus.req1_last ? '0 : seq1_q + SEQ_W'(1);
            state_d = bus.req1_last ? ST_OPEN : ST_LOCK1;
        end
    end

    // Response entry for the granted word
    always_comb begin
        push_entry_c      = '0;
        push_entry_c.crc  = crc5_word(gnt1_c ? bus.req1_data : bus.req0_data);
        push_entry_c.id   = gnt1_c;
        push_entry_c.last = gnt1_c ? bus.req1_last : bus.req0_last;
        push_entry_c.seq  = gnt1_c ? seq1_q : seq0_q;
    end

    // FIFO pointer, occupancy and storage next-state
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = push_entry_c;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OPEN;
            prio_q  <= 1'b0;
            seq0_q  <= '0;
            seq1_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            seq0_q  <= seq0_d;
            seq1_q  <= seq1_d;
        end
    end

    // FIFO registers; storage is cleared so the response fields read zero after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign bus.req0_ready = gnt0_c;
    assign bus.req1_ready = gnt1_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_crc    = head_c.crc;
    assign bus.rsp_id     = head_c.id;
    assign bus.rsp_last   = head_c.last;
    assign bus.rsp_seq    = head_c.seq;

endmodule

// File: tb/tb_crc5_arb.sv
// Bench for crc5_arb: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference of arbitration, sequencing and CRC.
module tb_crc5_arb;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [4:0] crc;
        logic       id;
        logic       last;
        logic [3:0] seq;
    } rsp_s;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } word_s;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    crc5_arb_if bus();

    crc5_arb #(.RSP_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic        vld [2];
    logic [63:0] dat [2];
    logic        lst [2];
    logic        rsp_rdy;

    assign bus.req0_valid = vld[0];
    assign bus.req0_data  = dat[0];
    assign bus.req0_last  = lst[0];
    assign bus.req1_valid = vld[1];
    assign bus.req1_data  = dat[1];
    assign bus.req1_last  = lst[1];
    assign bus.rsp_ready  = rsp_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    rsp_s  exp_q [$];
    int    seq_cnt [2];
    int    lock_id;
    int    tie_win;
    bit    post_reset;
    bit    stall_prev;
    rsp_s  prev_f;

    // Stimulus and observation logs
    word_s feed [2][$];
    rsp_s  pop_log [$];
    int    acc_log [$];
    int    gap_pct;
    int    rdy_pct;

    logic [63:0] single_data [4] = '{64'h1, 64'h2, 64'h8000_0000_0000_0000, 64'h0};
    logic [4:0]  single_crc  [4] = '{5'h05, 5'h0A, 5'h0A, 5'h00};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Remainder of d(x)*x^5 by long division over GF(2)
    function automatic logic [4:0] ref_crc(input logic [63:0] d);
        logic [68:0] m;
        m = {d, 5'b0};
        for (int b = 68; b >= 5; b--) begin
            if (m[b]) m[b -: 6] = m[b -: 6] ^ 6'b100101;
        end
        return m[4:0];
    endfunction

    task automatic push_word(input int n, input logic [63:0] d, input logic l);
        word_s w;
        w.data = d;
        w.last = l;
        feed[n].push_back(w);
    endtask

    task automatic model_reset();
        exp_q.delete();
        seq_cnt[0] = 0;
        seq_cnt[1] = 0;
        lock_id    = -1;
        tie_win    = 0;
        post_reset = 1'b1;
        stall_prev = 1'b0;
    endtask

    // One clock: present inputs at negedge, check #1 later, advance reference
    task automatic tick();
        int    g;
        bit    acc [2];
        rsp_s  e;
        rsp_s  cur;
        word_s w;

        for (int n = 0; n < 2; n++) begin
            if (!vld[n] && feed[n].size() > 0 && $urandom_range(99) >= gap_pct) begin
                w      = feed[n].pop_front();
                vld[n] = 1'b1;
                dat[n] = w.data;
                lst[n] = w.last;
            end
        end
        rsp_rdy = ($urandom_range(99) < rdy_pct);
        #1;
        cur.crc  = bus.rsp_crc;
        cur.id   = bus.rsp_id;
        cur.last = bus.rsp_last;
        cur.seq  = bus.rsp_seq;
        acc[0]   = bus.req0_ready && vld[0];
        acc[1]   = bus.req1_ready && vld[1];

        if (!rst_n) begin
            check("rst_ready0", bus.req0_ready, 0);
            check("rst_ready1", bus.req1_ready, 0);
            check("rst_rsp_valid", bus.rsp_valid, 0);
            model_reset();
            @(negedge clk);
            vld[0] = 1'b0;
            vld[1] = 1'b0;
            feed[0].delete();
            feed[1].delete();
            return;
        end

        if (post_reset) begin
            check("post_rst_crc", cur.crc, 0);
            check("post_rst_id", cur.id, 0);
            check("post_rst_last", cur.last, 0);
            check("post_rst_seq", cur.seq, 0);
            post_reset = 1'b0;
        end

        g = -1;
        if (exp_q.size() < DEPTH) begin
            if (lock_id >= 0) begin
                if (vld[lock_id]) g = lock_id;
            end else if (vld[0] && vld[1]) begin
                g = tie_win;
            end else if (vld[0]) begin
                g = 0;
            end else if (vld[1]) begin
                g = 1;
            end
        end
        check("ready0", bus.req0_ready, g == 0);
        check("ready1", bus.req1_ready, g == 1);
        check("rsp_valid", bus.rsp_valid, exp_q.size() != 0);

        if (stall_prev && bus.rsp_valid) begin
            check("stable_crc", cur.crc, prev_f.crc);
            check("stable_seq", cur.seq, prev_f.seq);
        end
        if (bus.rsp_valid && exp_q.size() != 0) begin
            check("rsp_crc", cur.crc, exp_q[0].crc);
            check("rsp_id", cur.id, exp_q[0].id);
            check("rsp_last", cur.last, exp_q[0].last);
            check("rsp_seq", cur.seq, exp_q[0].seq);
        end
        stall_prev = bus.rsp_valid && !rsp_rdy;
        prev_f     = cur;

        if (bus.rsp_valid && rsp_rdy && exp_q.size() != 0) begin
            pop_log.push_back(cur);
            e = exp_q.pop_front();
        end
        if (g >= 0) begin
            e.crc  = ref_crc(dat[g]);
            e.id   = 1'(g);
            e.last = lst[g];
            e.seq  = 4'(seq_cnt[g]);
            exp_q.push_back(e);
            seq_cnt[g] = lst[g] ? 0 : (seq_cnt[g] + 1) % 16;
            tie_win    = 1 - g;
            lock_id    = lst[g] ? -1 : g;
        end
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) acc_log.push_back(n);
        end

        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            if (acc[n]) vld[n] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        int  k;
        bit  busy;
        k    = 0;
        busy = 1'b1;
        while (busy && k < max_cycles) begin
            tick();
            k++;
            busy = (exp_q.size() != 0) || (feed[0].size() != 0) || (feed[1].size() != 0)
                   || vld[0] || vld[1];
        end
        check("drain_done", busy, 0);
    endtask

    initial begin
        vld[0]  = 1'b0;
        vld[1]  = 1'b0;
        dat[0]  = '0;
        dat[1]  = '0;
        lst[0]  = 1'b0;
        lst[1]  = 1'b0;
        rsp_rdy = 1'b1;
        gap_pct = 0;
        rdy_pct = 100;
        rst_n   = 1'b0;
        model_reset();

        @(negedge clk);
        do_reset();
        tick();

        // Single-word frames with known CRC values, latency 1
        for (int i = 0; i < 4; i++) begin
            pop_log.delete();
            push_word(0, single_data[i], 1'b1);
            tick();
            tick();
            check("single_count", pop_log.size(), 1);
            if (pop_log.size() == 1) begin
                check("single_crc", pop_log[0].crc, single_crc[i]);
                check("single_id", pop_log[0].id, 0);
                check("single_seq", pop_log[0].seq, 0);
                check("single_last", pop_log[0].last, 1);
            end
        end

        // Tie after reset alternates 0,1,0,1
        do_reset();
        acc_log.delete();
        pop_log.delete();
        for (int i = 0; i < 4; i++) begin
            push_word(0, {$urandom, $urandom}, 1'b1);
            push_word(1, {$urandom, $urandom}, 1'b1);
        end
        drain(60);
        check("tie_count", acc_log.size(), 8);
        if (acc_log.size() == 8) begin
            for (int i = 0; i < 8; i++) check("tie_grant", acc_log[i], i % 2);
        end
        check("tie_rsp_count", pop_log.size(), 8);
        if (pop_log.size() == 8) begin
            for (int i = 0; i < 8; i++) check("tie_rsp_id", pop_log[i].id, i % 2);
        end

        // Frame lock: req0 three-word frame holds off req1
        pop_log.delete();
        push_word(0, {$urandom, $urandom}, 1'b0);
        push_word(0, {$urandom, $urandom}, 1'b0);
        push_word(0, {$urandom, $urandom}, 1'b1);
        push_word(1, {$urandom, $urandom}, 1'b1);
        drain(60);
        check("lock_count", pop_log.size(), 4);
        if (pop_log.size() == 4) begin
            check("lock_seq0", pop_log[0].seq, 0);
            check("lock_seq1", pop_log[1].seq, 1);
            check("lock_seq2", pop_log[2].seq, 2);
            check("lock_id2", pop_log[2].id, 0);
            check("lock_id3", pop_log[3].id, 1);
            check("lock_seq3", pop_log[3].seq, 0);
        end

        // Backpressure: exactly DEPTH words accepted while stalled
        rdy_pct = 0;
        acc_log.delete();
        pop_log.delete();
        for (int i = 0; i < 6; i++) push_word(0, {$urandom, $urandom}, 1'b1);
        repeat (8) tick();
        check("bp_accepted", acc_log.size(), DEPTH);
        check("bp_req_waiting", vld[0], 1);
        rdy_pct = 100;
        drain(60);
        check("bp_drained", pop_log.size(), 6);

        // Seq wrap on a long req1 frame
        pop_log.delete();
        for (int i = 0; i < 17; i++) push_word(1, {$urandom, $urandom}, 1'b0);
        push_word(1, {$urandom, $urandom}, 1'b1);
        drain(200);
        check("wrap_count", pop_log.size(), 18);
        if (pop_log.size() == 18) begin
            for (int i = 0; i < 17; i++) check("wrap_seq", pop_log[i].seq, i % 16);
            check("wrap_close_seq", pop_log[17].seq, 1);
        end

        // Reset mid-frame with two entries queued
        rdy_pct = 0;
        push_word(0, {$urandom, $urandom}, 1'b0);
        push_word(0, {$urandom, $urandom}, 1'b0);
        push_word(0, {$urandom, $urandom}, 1'b0);
        tick();
        tick();
        check("mid_fill", exp_q.size(), 2);
        do_reset();
        tick();
        rdy_pct = 100;
        pop_log.delete();
        push_word(0, {$urandom, $urandom}, 1'b1);
        push_word(1, {$urandom, $urandom}, 1'b1);
        drain(60);
        check("mid_count", pop_log.size(), 2);
        if (pop_log.size() == 2) begin
            check("mid_first_id", pop_log[0].id, 0);
            check("mid_first_seq", pop_log[0].seq, 0);
        end

        // Random traffic with gaps, backpressure and one reset
        gap_pct = 30;
        rdy_pct = 70;
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                do_reset();
            end else begin
                for (int n = 0; n < 2; n++) begin
                    if (feed[n].size() == 0 && $urandom_range(3) == 0) begin
                        int len;
                        len = $urandom_range(5, 1);
                        for (int k = 0; k < len; k++)
                            push_word(n, {$urandom, $urandom}, k == len - 1);
                    end
                end
                tick();
            end
        end
        rdy_pct = 100;
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
